// File: rtl/mult_arb_pkg.sv
// Shared types and sizes for the multiplier-sharing arbiter.
package mult_arb_pkg;

    localparam int unsigned N_REQ       = 4;
    localparam int unsigned IDX_W       = 2;
    localparam int unsigned A_W         = 16;
    localparam int unsigned B_W         = 32;
    localparam int unsigned R_W         = 32;
    localparam int unsigned TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        ARM,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Round-robin winner select over four requesters, searching upward from ptr with wrap.
module rr_pick4
    import mult_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win_c,
    output logic [IDX_W-1:0] idx_c
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        win_c = '0;
        idx_c = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            cand = ptr + IDX_W'(k);
            if (!found && req[cand]) begin
                found       = 1'b1;
                win_c[cand] = 1'b1;
                idx_c       = cand;
            end
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// Arbitrates four requesters onto one shared booth_mult.
// Optional WAIT timeout with sticky err port: define MULT_ARB_TIMEOUT_EN.
module mult_share_arb #(
    parameter int unsigned N_REQ   = mult_arb_pkg::N_REQ,
    parameter int unsigned TIMEOUT = mult_arb_pkg::TIMEOUT_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_REQ-1:0]                    req,
    input  logic [N_REQ*mult_arb_pkg::A_W-1:0]  req_a,
    input  logic [N_REQ*mult_arb_pkg::B_W-1:0]  req_b,
    output logic [N_REQ-1:0]                    gnt,
    output logic [N_REQ-1:0]                    done,
    output logic [mult_arb_pkg::R_W-1:0]        result,
    output logic                                busy,
    output logic                                m_rst,
    output logic                                m_en,
    output logic [mult_arb_pkg::A_W-1:0]        m_a,
    output logic [mult_arb_pkg::B_W-1:0]        m_b,
    input  logic                                m_busy,
    input  logic [mult_arb_pkg::R_W-1:0]        m_r
`ifdef MULT_ARB_TIMEOUT_EN
    ,
    output logic                                err
`endif
);

    import mult_arb_pkg::*;

    if (N_REQ != 4 || TIMEOUT < 2) begin : g_bad_cfg
        $error("mult_share_arb: N_REQ must be 4 and TIMEOUT at least 2");
    end

    state_t           state, state_d;
    logic [IDX_W-1:0] ptr, ptr_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [N_REQ-1:0] pick_win;
    logic [IDX_W-1:0] pick_idx;

    logic [N_REQ-1:0] gnt_d;
    logic [N_REQ-1:0] done_d;
    logic [R_W-1:0]   result_d;
    logic             busy_d;
    logic             m_rst_d;
    logic             m_en_d;
    logic [A_W-1:0]   m_a_d;
    logic [B_W-1:0]   m_b_d;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int unsigned TCNT_W = $clog2(TIMEOUT);
    logic [TCNT_W-1:0] tcnt, tcnt_d;
    logic              err_d;
`endif

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr),
        .win_c (pick_win),
        .idx_c (pick_idx)
    );

    // Next state plus registered outputs decoded from the state being entered.
    always_comb begin
        state_d  = state;
        ptr_d    = ptr;
        idx_d    = idx;
        gnt_d    = gnt;
        done_d   = '0;
        result_d = result;
        busy_d   = 1'b0;
        m_rst_d  = 1'b0;
        m_en_d   = 1'b0;
        m_a_d    = m_a;
        m_b_d    = m_b;
`ifdef MULT_ARB_TIMEOUT_EN
        tcnt_d   = tcnt;
        err_d    = err;
`endif

        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_d = LOAD;
                    idx_d   = pick_idx;
                    gnt_d   = pick_win;
                    m_a_d   = req_a[{pick_idx, 4'b0000} +: A_W];
                    m_b_d   = req_b[{pick_idx, 5'b00000} +: B_W];
                end
            end
            LOAD:  state_d = START;
            START: state_d = ARM;
            ARM: begin
                state_d = WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
                tcnt_d  = '0;
`endif
            end
            WAIT: begin
                if (!m_busy) begin
                    result_d = m_r;
                    state_d  = DONE;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    tcnt_d = tcnt + TCNT_W'(1);
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = idx + IDX_W'(1);
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            gnt_d = '0;
        end
        if (state_d != IDLE) begin
            busy_d = 1'b1;
        end
        if (state_d == IDLE || state_d == DONE) begin
            m_rst_d = 1'b1;
        end
        if (state_d == START) begin
            m_en_d = 1'b1;
        end
        if (state_d == DONE) begin
            done_d = gnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            idx    <= '0;
            gnt    <= '0;
            done   <= '0;
            result <= '0;
            busy   <= 1'b0;
            m_rst  <= 1'b1;
            m_en   <= 1'b0;
            m_a    <= '0;
            m_b    <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            tcnt   <= '0;
            err    <= 1'b0;
`endif
        end else begin
            state  <= state_d;
            ptr    <= ptr_d;
            idx    <= idx_d;
            gnt    <= gnt_d;
            done   <= done_d;
            result <= result_d;
            busy   <= busy_d;
            m_rst  <= m_rst_d;
            m_en   <= m_en_d;
            m_a    <= m_a_d;
            m_b    <= m_b_d;
`ifdef MULT_ARB_TIMEOUT_EN
            tcnt   <= tcnt_d;
            err    <= err_d;
`endif
        end
    end

endmodule

// File: doc/mult_share_arb.md
MULT_SHARE_ARB -- requirements
Module: mult_share_arb

Interface
REQ-001 The module SHALL have parameter N_REQ, default 4, meaning the number of requesters; the value is fixed at 4 in this revision.
REQ-002 The module SHALL have parameter TIMEOUT, default 64, meaning the maximum number of WAIT cycles; it is used only under MULT_ARB_TIMEOUT_EN.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port req, input, 4 bits: per-requester request, held until the matching done.
REQ-006 The module SHALL have port req_a, input, 64 bits: four 16-bit signed dt operands; requester i uses bits [16i+15:16i].
REQ-007 The module SHALL have port req_b, input, 128 bits: four 32-bit signed operands; requester i uses bits [32i+31:32i].
REQ-008 The module SHALL have port gnt, output, 4 bits: one-hot grant, held from LOAD through DONE.
REQ-009 The module SHALL have port done, output, 4 bits: one-cycle completion pulse to the granted requester.
REQ-010 The module SHALL have port result, output, 32 bits: the product, registered and valid from the done pulse until the next capture.
REQ-011 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 The module SHALL have multiplier-side ports m_rst (out, 1), m_en (out, 1), m_a (out, 16), m_b (out, 32), m_busy (in, 1) and m_r (in, 32), connecting to one shared booth_mult.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, LOAD, START, ARM, WAIT and DONE.
REQ-014 In IDLE with any req bit high, the block SHALL pick the winner round-robin, starting at pointer ptr and moving upward with wrap, and go to LOAD.
REQ-015 In IDLE with req all zero, the block SHALL stay in IDLE with m_rst=1, m_en=0 and gnt=0.
REQ-016 In LOAD, the block SHALL register the winner's operands onto m_a/m_b, drive m_rst=0 and m_en=0, and go to START.
REQ-017 In START, the block SHALL drive m_en=1 for exactly one cycle and go to ARM.
REQ-018 In ARM, the block SHALL ignore m_busy (one-cycle settle) and go to WAIT.
REQ-019 In WAIT, when m_busy=0 the block SHALL capture m_r into result and go to DONE; otherwise it stays in WAIT.
REQ-020 In DONE, the block SHALL assert done[winner] for one cycle, drive m_rst=1, clear gnt, set ptr=(winner+1) mod 4, and go to IDLE.
REQ-021 m_a and m_b SHALL stay stable from LOAD through WAIT; requester operand changes after LOAD SHALL have no effect.
REQ-022 If the granted req drops mid-operation, the operation SHALL complete and done SHALL still pulse.
REQ-023 A requester still holding req after its done SHALL NOT be re-granted while another req bit is pending.
REQ-024 result SHALL be the 32 LSBs of the signed product (the booth_mult width).
REQ-025 The minimum latency from a req edge seen in IDLE to done SHALL be 5 cycles plus the extra cycles m_busy stays high in WAIT.

Reset
REQ-026 While rst=1, the block SHALL force state=IDLE, ptr=0, gnt=0, done=0, result=0, busy=0, m_en=0, m_rst=1, m_a=0 and m_b=0.
REQ-027 Reset in any state, including mid-WAIT, SHALL abort the operation without any done pulse, and m_rst=1 SHALL re-initialise the multiplier.

Configuration
REQ-028 With MULT_ARB_TIMEOUT_EN defined, the block SHALL count WAIT cycles and, at TIMEOUT, force result=0, set a sticky output err (1 bit, cleared only by rst), and go to DONE.
REQ-029 Without MULT_ARB_TIMEOUT_EN, there SHALL be no counter and no err port, and WAIT SHALL be unbounded.

Structure
REQ-030 Package mult_arb_pkg SHALL hold the state enum, N_REQ, the operand widths (16/32) and the TIMEOUT default.
REQ-031 The round-robin winner select SHALL be one sub-module, rr_pick4 (inputs req and ptr; outputs one-hot winner and its index).
REQ-032 booth_mult SHALL be instantiated outside this block.

Verification
REQ-033 Single request: req=0001, a=3, b=5, model busy 8 cycles -> result=15, done=0001 exactly once, gnt=0001 for the whole operation.
REQ-034 Signed operands: a=16'hFFFE, b=7 -> result=32'hFFFFFFF2.
REQ-035 Simultaneous requests: req=1111 from reset -> done order 0,1,2,3; then req=1010 -> order 1,3.
REQ-036 Fairness: req[0] held continuously with req[2] pulsed -> grants alternate 0,2,0.
REQ-037 Reset mid-WAIT: rst for 1 cycle -> no done pulse, m_rst=1, state IDLE; a re-issued request completes correctly.
REQ-038 Timeout (macro on, TIMEOUT=64): m_busy stuck high -> done after 64 WAIT cycles, result=0, err=1 until rst.
